pixel_ram_scheduler: RTL

//  Time-shares the single 16Kx16 pixel SPRAM between the VGA read path and buffered brush writes.

---
 rtl/colors_pkg.sv | 6 +
 rtl/pixel_ram_sched_pkg.sv | 17 +
 rtl/pixel_ram_scheduler_fifo.sv | 46 ++++
 rtl/pixel_ram_scheduler.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/colors_pkg.sv
// Shared color codes for the VGA palette path.
package colors_pkg;

    localparam logic [2:0] OUTSIDE = 3'b111;

endpackage

// File: rtl/pixel_ram_sched_pkg.sv
// Types and constants shared by the pixel SPRAM scheduler and its write queue.
package pixel_ram_sched_pkg;

    typedef enum logic {
        INIT_CLEAR,
        RUN
    } sched_state_t;

    typedef struct packed {
        logic [6:0] x;
        logic [6:0] y;
        logic [2:0] color;
    } pix_wr_t;

    localparam logic [13:0] CLEAR_LAST = 14'd16383;

endpackage

// File: rtl/pixel_ram_scheduler_fifo.sv
// Brush-write queue: synchronous FIFO of pix_wr_t with flush.
module pixel_wr_fifo
    import pixel_ram_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  logic    flush,
    input  pix_wr_t din,
    output pix_wr_t dout,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    pix_wr_t        mem [DEPTH];
    logic [AW:0]    wp;
    logic [AW:0]    rp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wp[AW-1:0]] <= din;
    end

    assign dout  = mem[rp[AW-1:0]];
    assign empty = (wp == rp);
    // Extra pointer bit separates full from empty when the indices match.
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

endmodule

// File: rtl/pixel_ram_scheduler.sv
// Time-shares the pixel SPRAM between VGA reads and queued brush writes,
// and sequences the boot-time and requested canvas clears.
module pixel_ram_scheduler
    import pixel_ram_sched_pkg::*;
    import colors_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 8,
    parameter int         CANVAS_BITS = 7,
    parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wx,
    input  logic [7:0]  wy,
    input  logic [2:0]  wr_color,
    output logic        wr_drop,
    input  logic        clear_req,
    output logic        busy,
    input  logic [9:0]  rx,
    input  logic [9:0]  ry,
    output logic [2:0]  color_code,
    output logic [13:0] ram_adr,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata
);

    sched_state_t state, state_n;
    logic         phase, phase_n;
    logic         clearing, clearing_n;
    logic [13:0]  clr_cnt, clr_cnt_n;

    logic         rd_vld_q;
    logic         oob_q;
    logic         rd_oob;
    logic         wr_oob;

    pix_wr_t      head;
    pix_wr_t      wr_ent;
    logic         full;
    logic         empty;
    logic         accept;
    logic         push;
    logic         pop;
    logic         flush;
    logic         we_raw;
    logic         unused_rdata;

    assign unused_rdata = ^ram_rdata[15:3];

    assign rd_oob = (|rx[9:CANVAS_BITS]) | (|ry[9:CANVAS_BITS]);
    assign wr_oob = (|wx[7:CANVAS_BITS]) | (|wy[7:CANVAS_BITS]);

    assign busy     = (state == INIT_CLEAR) | clearing;
    assign wr_ready = ~full & ~busy;
    assign accept   = wr_valid & wr_ready;
    assign wr_drop  = accept & wr_oob;
    assign flush    = clear_req & (state == RUN) & ~clearing;
    assign push     = accept & ~wr_oob & ~flush;
    assign wr_ent   = '{x: wx[6:0], y: wy[6:0], color: wr_color};

    pixel_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (wr_ent),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT_CLEAR;
            phase    <= 1'b0;
            clearing <= 1'b0;
            clr_cnt  <= '0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            clearing <= clearing_n;
            clr_cnt  <= clr_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        clearing_n = clearing;
        clr_cnt_n  = clr_cnt;
        pop        = 1'b0;
        we_raw     = 1'b0;
        ram_adr    = '0;
        ram_wdata  = '0;
        unique case (state)
            INIT_CLEAR: begin
                we_raw    = 1'b1;
                ram_adr   = clr_cnt;
                ram_wdata = {13'b0, CLEAR_COLOR};
                clr_cnt_n = clr_cnt + 1'b1;
                if (clr_cnt == CLEAR_LAST) begin
                    state_n = RUN;
                    phase_n = 1'b0;
                end
            end
            RUN: begin
                phase_n = ~phase;
                if (!phase) begin
                    ram_adr = {ry[6:0], rx[6:0]};
                end else if (clearing) begin
                    we_raw    = 1'b1;
                    ram_adr   = clr_cnt;
                    ram_wdata = {13'b0, CLEAR_COLOR};
                    clr_cnt_n = clr_cnt + 1'b1;
                    if (clr_cnt == CLEAR_LAST) clearing_n = 1'b0;
                end else if (!empty && !flush) begin
                    // A flush in this slot discards the head as well.
                    we_raw    = 1'b1;
                    ram_adr   = {head.y, head.x};
                    ram_wdata = {13'b0, head.color};
                    pop       = 1'b1;
                end
                if (flush) begin
                    clearing_n = 1'b1;
                    clr_cnt_n  = '0;
                end
            end
            default: state_n = INIT_CLEAR;
        endcase
    end

    assign ram_we = we_raw & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_q   <= 1'b0;
            oob_q      <= 1'b0;
            color_code <= '0;
        end else begin
            rd_vld_q <= (state == RUN) & ~phase;
            oob_q    <= rd_oob;
            if (rd_vld_q) color_code <= oob_q ? OUTSIDE : ram_rdata[2:0];
        end
    end

endmodule
